// File: rtl/rf_wb_queue_if.sv
// Register-file write-back queue bus: producer handshake, write port and decode lookups.
// The master side is the producer/decode/testbench; the slave side is rf_wb_queue.
interface rf_wb_queue_if;
   logic        in_valid;
   logic [2:0]  in_regsel;
   logic [15:0] in_data;
   logic        in_ready;
   logic        drain_stall;
   logic        write;
   logic [2:0]  writeregsel;
   logic [15:0] writedata;
   logic [2:0]  look1sel;
   logic [2:0]  look2sel;
   logic        look1hit;
   logic        look2hit;
   logic [15:0] look1data;
   logic [15:0] look2data;

   modport master (
      output in_valid, in_regsel, in_data, drain_stall, look1sel, look2sel,
      input  in_ready, write, writeregsel, writedata,
             look1hit, look2hit, look1data, look2data
   );

   modport slave (
      input  in_valid, in_regsel, in_data, drain_stall, look1sel, look2sel,
      output in_ready, write, writeregsel, writedata,
             look1hit, look2hit, look1data, look2data
   );
endinterface

// File: rtl/rf_wb_queue.sv
// Circular write-back queue in front of the register-file write port, with optional
// youngest-match forwarding to two decode lookups (enabled by macro RF_WB_QUEUE_FWD_EN).
//
// state      | meaning
// ST_EMPTY   | count = 0, write port idle, outputs forced to 0
// ST_PARTIAL | 0 < count < DEPTH, accepting and draining
// ST_FULL    | count = DEPTH, in_ready low
module rf_wb_queue #(
   parameter int DEPTH = 4
) (
   input logic          clk,
   input logic          rst,
   rf_wb_queue_if.slave wb
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {ST_EMPTY, ST_PARTIAL, ST_FULL} state_t;

   state_t           state_q;
   state_t           state_d;
   logic [PTR_W-1:0] head_q;
   logic [PTR_W-1:0] tail_q;
   logic [CNT_W-1:0] count_q;
   logic [2:0]       regsel_mem [DEPTH];
   logic [15:0]      data_mem   [DEPTH];
   logic             push;
   logic             pop;
   logic             nonempty;

   assign nonempty       = (state_q != ST_EMPTY);
   assign wb.in_ready    = (state_q != ST_FULL) && !rst;
   assign push           = wb.in_valid && wb.in_ready;
   assign wb.write       = nonempty && !wb.drain_stall && !rst;
   assign pop            = wb.write;
   assign wb.writeregsel = nonempty ? regsel_mem[head_q] : 3'd0;
   assign wb.writedata   = nonempty ? data_mem[head_q] : 16'd0;

   always_comb begin
      state_d = state_q;
      case ({push, pop})
         2'b10:   state_d = (count_q == CNT_W'(DEPTH - 1)) ? ST_FULL : ST_PARTIAL;
         2'b01:   state_d = (count_q == CNT_W'(1)) ? ST_EMPTY : ST_PARTIAL;
         default: state_d = state_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         if (push) tail_q <= tail_q + 1'b1;
         if (pop)  head_q <= head_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // push is already gated by reset through in_ready
   always_ff @(posedge clk) begin
      if (push) begin
         regsel_mem[tail_q] <= wb.in_regsel;
         data_mem[tail_q]   <= wb.in_data;
      end
   end

`ifdef RF_WB_QUEUE_FWD_EN
   logic [DEPTH-1:0] valid_q;
   logic             hit1;
   logic             hit2;
   logic [15:0]      data1;
   logic [15:0]      data2;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else begin
         if (pop)  valid_q[head_q] <= 1'b0;
         if (push) valid_q[tail_q] <= 1'b1;
      end
   end

   // Walk oldest to youngest so the last match seen is the youngest pending write.
   always_comb begin
      logic [PTR_W-1:0] idx;
      idx   = '0;
      hit1  = 1'b0;
      hit2  = 1'b0;
      data1 = '0;
      data2 = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head_q + PTR_W'(i);
         if (valid_q[idx] && (regsel_mem[idx] == wb.look1sel)) begin
            hit1  = 1'b1;
            data1 = data_mem[idx];
         end
         if (valid_q[idx] && (regsel_mem[idx] == wb.look2sel)) begin
            hit2  = 1'b1;
            data2 = data_mem[idx];
         end
      end
   end

   assign wb.look1hit  = hit1 && !rst;
   assign wb.look2hit  = hit2 && !rst;
   assign wb.look1data = rst ? 16'd0 : data1;
   assign wb.look2data = rst ? 16'd0 : data2;
`else
   assign wb.look1hit  = 1'b0;
   assign wb.look2hit  = 1'b0;
   assign wb.look1data = 16'd0;
   assign wb.look2data = 16'd0;
`endif
endmodule

// File: tb/tb_rf_wb_queue.sv
// Scoreboard bench for rf_wb_queue: directed scenarios followed by random traffic,
// checked against a queue-based reference of pending writes.
module tb_rf_wb_queue;
   localparam int DEPTH = 4;

   typedef struct {
      logic [2:0]  r;
      logic [15:0] d;
   } ent_t;

   logic clk;
   logic rst;
   rf_wb_queue_if bus ();

   rf_wb_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .wb(bus));

   ent_t model_q[$];
   ent_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void ref_look(input logic [2:0] sel, output logic hit, output logic [15:0] d);
      hit = 1'b0;
      d   = 16'd0;
`ifdef RF_WB_QUEUE_FWD_EN
      if (!rst) begin
         for (int i = model_q.size() - 1; i >= 0; i--) begin
            if (model_q[i].r == sel) begin
               hit = 1'b1;
               d   = model_q[i].d;
               break;
            end
         end
      end
`endif
   endfunction

   task automatic check_model();
      int          n;
      logic        eh;
      logic [15:0] ed;
      n = model_q.size();
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, (!rst && n != DEPTH)});
      chk("write", {31'd0, bus.write}, {31'd0, (!rst && n != 0 && !bus.drain_stall)});
      chk("writeregsel", {29'd0, bus.writeregsel}, (n != 0) ? {29'd0, model_q[0].r} : 32'd0);
      chk("writedata", {16'd0, bus.writedata}, (n != 0) ? {16'd0, model_q[0].d} : 32'd0);
      ref_look(bus.look1sel, eh, ed);
      chk("look1hit", {31'd0, bus.look1hit}, {31'd0, eh});
      chk("look1data", {16'd0, bus.look1data}, {16'd0, ed});
      ref_look(bus.look2sel, eh, ed);
      chk("look2hit", {31'd0, bus.look2hit}, {31'd0, eh});
      chk("look2data", {16'd0, bus.look2data}, {16'd0, ed});
   endtask

   task automatic drive(input logic v, input logic [2:0] sel, input logic [15:0] d,
                        input logic st, input logic [2:0] l1, input logic [2:0] l2,
                        input logic r);
      bus.in_valid    = v;
      bus.in_regsel   = sel;
      bus.in_data     = d;
      bus.drain_stall = st;
      bus.look1sel    = l1;
      bus.look2sel    = l2;
      rst             = r;
      #2;
      check_model();
   endtask

   task automatic tick();
      logic acc;
      logic pp;
      ent_t e;
      acc = !rst && bus.in_valid && (model_q.size() < DEPTH);
      pp  = !rst && (model_q.size() > 0) && !bus.drain_stall;
      e.r = bus.in_regsel;
      e.d = bus.in_data;
      @(posedge clk);
      if (rst) begin
         model_q.delete();
         sb_q.delete();
      end else begin
         if (pp) void'(model_q.pop_front());
         if (acc) begin
            model_q.push_back(e);
            sb_q.push_back(e);
         end
      end
      #1;
   endtask

   task automatic cycle(input logic v, input logic [2:0] sel, input logic [15:0] d,
                        input logic st, input logic r);
      drive(v, sel, d, st, 3'd5, 3'd6, r);
      tick();
   endtask

   // Monitor: every retired write must match the oldest scoreboard entry.
   initial begin
      ent_t e;
      forever begin
         @(negedge clk);
         if (bus.write === 1'b1) begin
            if (sb_q.size() == 0) begin
               chk("sb_unexpected_write", {29'd0, bus.writeregsel}, 32'hFFFF_FFFF);
            end else begin
               e = sb_q.pop_front();
               chk("sb_regsel", {29'd0, bus.writeregsel}, {29'd0, e.r});
               chk("sb_data", {16'd0, bus.writedata}, {16'd0, e.d});
            end
         end
      end
   end

   initial begin
      rst             = 1'b1;
      bus.in_valid    = 1'b0;
      bus.in_regsel   = 3'd0;
      bus.in_data     = 16'd0;
      bus.drain_stall = 1'b0;
      bus.look1sel    = 3'd0;
      bus.look2sel    = 3'd0;
      @(posedge clk);
      #1;

      // reset state and first-write latency
      drive(1'b1, 3'd1, 16'h5555, 1'b0, 3'd1, 3'd2, 1'b1);
      chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      tick();
      drive(1'b1, 3'd3, 16'h1234, 1'b0, 3'd3, 3'd4, 1'b0);
      chk("r029_idle_write", {31'd0, bus.write}, 32'd0);
      tick();
      drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd3, 3'd4, 1'b0);
      chk("r029_write", {31'd0, bus.write}, 32'd1);
      chk("r029_sel", {29'd0, bus.writeregsel}, 32'd3);
      chk("r029_data", {16'd0, bus.writedata}, 32'h1234);
      tick();
      drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd3, 3'd4, 1'b0);
      chk("r029_after", {31'd0, bus.write}, 32'd0);
      tick();

      // stalled fill, refused 5th push, in-order drain
      for (int i = 1; i <= 4; i++) cycle(1'b1, 3'(i), 16'(i * 16'h11), 1'b1, 1'b0);
      drive(1'b1, 3'd5, 16'h0055, 1'b1, 3'd1, 3'd4, 1'b0);
      chk("r030_full_ready", {31'd0, bus.in_ready}, 32'd0);
      tick();
      for (int i = 1; i <= 4; i++) begin
         drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 1'b0);
         chk("r030_drain_sel", {29'd0, bus.writeregsel}, 32'(i));
         tick();
      end
      cycle(1'b0, 3'd0, 16'h0, 1'b0, 1'b0);

      // full + simultaneous pop/push, then wrap-around
      for (int i = 0; i < 4; i++) cycle(1'b1, 3'(i), 16'hA000 + 16'(i), 1'b1, 1'b0);
      drive(1'b1, 3'd7, 16'hCAFE, 1'b0, 3'd7, 3'd0, 1'b0);
      chk("r031_refused", {31'd0, bus.in_ready}, 32'd0);
      tick();
      drive(1'b1, 3'd7, 16'hBEEF, 1'b1, 3'd7, 3'd0, 1'b0);
      chk("r031_accept", {31'd0, bus.in_ready}, 32'd1);
      tick();
      for (int i = 0; i < 12; i++) cycle(1'b1, 3'(i), 16'hB000 + 16'(i), 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) cycle(1'b0, 3'd0, 16'h0, 1'b0, 1'b0);

      // forwarding of the youngest duplicate
      cycle(1'b1, 3'd5, 16'hAAAA, 1'b1, 1'b0);
      cycle(1'b1, 3'd5, 16'hBBBB, 1'b1, 1'b0);
      drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 3'd6, 1'b0);
`ifdef RF_WB_QUEUE_FWD_EN
      chk("r032_hit1", {31'd0, bus.look1hit}, 32'd1);
      chk("r032_data1", {16'd0, bus.look1data}, 32'hBBBB);
`endif
      chk("r032_hit2", {31'd0, bus.look2hit}, 32'd0);
      tick();

      // reset during stall discards pending writes
      cycle(1'b1, 3'd2, 16'h2222, 1'b1, 1'b0);
      drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 3'd2, 1'b1);
      chk("r033_rst_hit", {31'd0, bus.look1hit}, 32'd0);
      tick();
      drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd5, 3'd2, 1'b0);
      chk("r033_write", {31'd0, bus.write}, 32'd0);
      chk("r033_hit", {31'd0, bus.look1hit | bus.look2hit}, 32'd0);
      tick();
      for (int i = 0; i < 4; i++) cycle(1'b0, 3'd0, 16'h0, 1'b0, 1'b0);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         drive(1'($urandom_range(0, 9) < 7), 3'($urandom), 16'($urandom),
               1'($urandom_range(0, 9) < 4), 3'($urandom), 3'($urandom),
               1'($urandom_range(0, 99) == 0));
         tick();
      end
      for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
      chk("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/rf_wb_queue.md
RF_WB_QUEUE -- requirements
Module: rf_wb_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of pending-write entries; legal values are powers of two from 2 to 16.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: a producer presents a register result.
REQ-005 The block SHALL have port in_regsel, input, 3 bits: destination register of the presented result.
REQ-006 The block SHALL have port in_data, input, 16 bits: the presented result value.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the queue accepts the presented result this cycle.
REQ-008 The block SHALL have port drain_stall, input, 1 bit: the register-file write port is unavailable this cycle.
REQ-009 The block SHALL have port write, output, 1 bit: the register-file write enable.
REQ-010 The block SHALL have port writeregsel, output, 3 bits: the register-file write address.
REQ-011 The block SHALL have port writedata, output, 16 bits: the register-file write data.
REQ-012 The block SHALL have ports look1sel and look2sel, input, 3 bits each: the register numbers being read by the decode stage.
REQ-013 The block SHALL have ports look1hit and look2hit, output, 1 bit each: a pending write exists for the corresponding lookup register.
REQ-014 The block SHALL have ports look1data and look2data, output, 16 bits each: the value of the youngest pending write for the corresponding lookup register.

Function
REQ-015 The block SHALL hold up to DEPTH entries {regsel, data} in a circular FIFO with head and tail pointers that wrap modulo DEPTH, and a count from 0 to DEPTH.
REQ-016 The block SHALL drive in_ready = (count != DEPTH) and rst low; it SHALL NOT pass a push through in the same cycle when the queue is full.
REQ-017 A push SHALL occur when in_valid and in_ready are both high; the entry is written at tail, the tail advances, and the entry is visible at head no earlier than the next cycle.
REQ-018 The block SHALL drive write = (count != 0) and not drain_stall and not rst; writeregsel and writedata SHALL be taken combinationally from the head entry.
REQ-019 A pop SHALL occur when write is high; the head advances at the clock edge.
REQ-020 When a push and a pop occur in the same cycle, count SHALL be unchanged and both pointers SHALL advance.
REQ-021 When the queue is empty, write, writeregsel and writedata SHALL all be 0.
REQ-022 While drain_stall is high, the head entry and its outputs SHALL hold stable and pushes SHALL continue until the queue is full.
REQ-023 Entries SHALL retire strictly in push order; duplicate destination registers SHALL each be written in order.
REQ-024 The block SHALL have no other state machine: the states are EMPTY (count=0), PARTIAL, and FULL (count=DEPTH), and transitions are determined only by push and pop.

Reset
REQ-025 When rst is high at a clock edge, count, head and tail SHALL become 0 and all entries SHALL be invalidated, regardless of any push or pop in that cycle.
REQ-026 While rst is high, in_ready, write, look1hit and look2hit SHALL be 0; a reset in the middle of a stall SHALL discard all pending writes.

Configuration
REQ-027 With macro RF_WB_QUEUE_FWD_EN defined, lookN SHALL search all valid entries, including the head being written this cycle, but not the same-cycle in_* input; on one or more matches, lookNhit SHALL be 1 and lookNdata SHALL be the data of the youngest match.
REQ-028 With RF_WB_QUEUE_FWD_EN undefined, look1hit, look2hit, look1data and look2data SHALL be constant 0, and no search logic SHALL be built.

Verification
REQ-029 Reset then push r3=0x1234, with drain_stall=0: the following cycle write=1, writeregsel=3 and writedata=0x1234; the cycle after that write=0.
REQ-030 With drain_stall=1, push 4 entries r1..r4 = 0x0011..0x0044: in_ready falls to 0 after the 4th push and a 5th push is refused; after release, writes r1..r4 appear in order on 4 consecutive cycles.
REQ-031 With the queue full, a simultaneous pop and push attempt is refused (in_ready=0); in the next cycle count=3 and a push is accepted; pointers are checked across wrap-around over 10 or more pushes.
REQ-032 With FWD_EN defined and drain_stall=1, push r5=0xAAAA then r5=0xBBBB and set look1sel=5: look1hit=1 and look1data=0xBBBB; with look2sel=6, look2hit=0.
REQ-033 With drain_stall=1 and 3 entries queued, assert rst for one cycle: the next cycle has count=0, write=0 and lookNhit=0, and no queued write appears after release.
